// File: rtl/param_sync_debounce.sv
// -----------------------------------------------------------------------------
// param_sync_debounce
//
// Multi-channel input conditioner for raw switches and buttons. Each channel
// is first brought into the i_clk domain through a STAGES-deep synchroniser
// chain. A per-channel stability counter then accepts a new level only after
// DB_CYCLES consecutive synchronised samples disagree with the current
// debounced level. Each accepted change also produces a one-cycle rise or
// fall pulse that is aligned with the updated level.
//
// Channels are fully independent: each one has its own chain, counter and
// output flops, built by the generate loop below.
//
// Parameters
//   WIDTH      number of independent channels
//   STAGES     synchroniser flops per channel (>= 2)
//   DB_CYCLES  consecutive stable samples needed to accept a new level (>= 1)
//
// Ports
//   i_clk    system clock; all state changes on the rising edge
//   i_reset  asynchronous, active-high; clears every flop as soon as it rises
//   i_press  [WIDTH] raw asynchronous inputs, one bit per channel
//   o_out    [WIDTH] debounced level per channel
//   o_rise   [WIDTH] one-cycle pulse, high in the first cycle o_out[i] shows 1
//   o_fall   [WIDTH] one-cycle pulse, high in the first cycle o_out[i] shows 0
//
// Latency: if the first rising edge that captures a new, held press value is
// edge k, then o_out changes at edge k + STAGES + DB_CYCLES - 1.
// -----------------------------------------------------------------------------
module param_sync_debounce #(
    parameter int WIDTH     = 4,
    parameter int STAGES    = 2,
    parameter int DB_CYCLES = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_press,
    output logic [WIDTH-1:0] o_out,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    // The counter only has to hold values 0 .. DB_CYCLES-1. It clears when
    // it reaches DB_CYCLES-1, so it can never wrap around.
    localparam int             CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

    // Reject parameter values that are not allowed when the design is
    // elaborated.
    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("param_sync_debounce: STAGES must be >= 2 (got %0d)", STAGES);
        end
        if (DB_CYCLES < 1) begin : g_bad_db
            $error("param_sync_debounce: DB_CYCLES must be >= 1 (got %0d)", DB_CYCLES);
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            // Bit 0 is the first synchroniser stage.
            // Bit STAGES-1 is the synchronised sample s.
            logic [STAGES-1:0] r_sync;
            logic [CW-1:0]     r_cnt;
            logic              r_out;
            logic              r_rise;
            logic              r_fall;

            logic              w_s;
            logic [CW-1:0]     w_cnt_next;
            logic              w_out_next;
            logic              w_rise_next;
            logic              w_fall_next;

            assign w_s = r_sync[STAGES-1];

            // Synchroniser chain: shift toward the MSB each clock.
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[STAGES-2:0], i_press[gi]};
                end
            end

            // Stability counter. It counts consecutive samples that disagree
            // with the current debounced level. Any sample that agrees (a
            // glitch ending early) sends the count back to zero. The pulses
            // default low, so each one lasts exactly one cycle.
            always_comb begin
                w_cnt_next  = r_cnt;
                w_out_next  = r_out;
                w_rise_next = 1'b0;
                w_fall_next = 1'b0;
                if (w_s == r_out) begin
                    w_cnt_next = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_out_next  = w_s;
                    w_cnt_next  = '0;
                    w_rise_next = w_s;
                    w_fall_next = ~w_s;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_cnt  <= '0;
                    r_out  <= 1'b0;
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else begin
                    r_cnt  <= w_cnt_next;
                    r_out  <= w_out_next;
                    r_rise <= w_rise_next;
                    r_fall <= w_fall_next;
                end
            end

            assign o_out[gi]  = r_out;
            assign o_rise[gi] = r_rise;
            assign o_fall[gi] = r_fall;
        end
    endgenerate

endmodule

// File: tb/tb_param_sync_debounce.sv
// -----------------------------------------------------------------------------
// Bench for param_sync_debounce.
//
// Two instances are built:
//   dut_a  default parameters (STAGES=2, DB_CYCLES=4)
//   dut_b  the STAGES=3, DB_CYCLES=1 variant
//
// The reference model does not use a counter. It keeps a history of the
// press values captured at each clock edge. At every edge it accepts a new
// level for a channel when the last DB synchronised samples all equal the
// opposite of that channel's current level. A synchronised sample seen at
// edge t is the press value captured at edge t-STAGES.
// -----------------------------------------------------------------------------
module tb_param_sync_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] press_a, press_b;
    logic [3:0] out_a, rise_a, fall_a;
    logic [3:0] out_b, rise_b, fall_b;

    int total = 0;
    int bad   = 0;

    always #50 clk = ~clk;

    param_sync_debounce #(.WIDTH(4), .STAGES(2), .DB_CYCLES(4)) dut_a (
        .i_clk   (clk),
        .i_reset (rst),
        .i_press (press_a),
        .o_out   (out_a),
        .o_rise  (rise_a),
        .o_fall  (fall_a)
    );

    param_sync_debounce #(.WIDTH(4), .STAGES(3), .DB_CYCLES(1)) dut_b (
        .i_clk   (clk),
        .i_reset (rst),
        .i_press (press_b),
        .o_out   (out_b),
        .o_rise  (rise_b),
        .o_fall  (fall_b)
    );

    // ---------------- reference model ----------------
    // h[0] holds the press value captured at the most recent previous edge.
    typedef logic [3:0] hist_t [16];

    hist_t      hist_a, hist_b;
    logic [3:0] ma_out, ma_rise, ma_fall;
    logic [3:0] mb_out, mb_rise, mb_fall;

    // Return the debounced level after this edge for stage count s and
    // debounce depth d.
    function automatic logic [3:0] window_accept(input hist_t h, input logic [3:0] cur,
                                                 input int s, input int d);
        logic [3:0] nxt;
        logic       want;
        logic       all_same;
        nxt = cur;
        for (int b = 0; b < 4; b++) begin
            want     = ~cur[b];
            all_same = 1'b1;
            for (int j = 0; j < d; j++) begin
                if (h[s-1+j][b] != want) all_same = 1'b0;
            end
            if (all_same) nxt[b] = want;
        end
        return nxt;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                hist_a[i] <= 4'b0;
                hist_b[i] <= 4'b0;
            end
            ma_out  <= 4'b0;
            ma_rise <= 4'b0;
            ma_fall <= 4'b0;
            mb_out  <= 4'b0;
            mb_rise <= 4'b0;
            mb_fall <= 4'b0;
        end else begin
            ma_out  <= window_accept(hist_a, ma_out, 2, 4);
            ma_rise <= window_accept(hist_a, ma_out, 2, 4) & ~ma_out;
            ma_fall <= ~window_accept(hist_a, ma_out, 2, 4) & ma_out;
            mb_out  <= window_accept(hist_b, mb_out, 3, 1);
            mb_rise <= window_accept(hist_b, mb_out, 3, 1) & ~mb_out;
            mb_fall <= ~window_accept(hist_b, mb_out, 3, 1) & mb_out;
            for (int i = 15; i > 0; i--) begin
                hist_a[i] <= hist_a[i-1];
                hist_b[i] <= hist_b[i-1];
            end
            hist_a[0] <= press_a;
            hist_b[0] <= press_b;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge, then compare every output with the
    // model.
    task automatic tick();
        @(negedge clk);
        chk("a_out_vs_model",  out_a,  ma_out);
        chk("a_rise_vs_model", rise_a, ma_rise);
        chk("a_fall_vs_model", fall_a, ma_fall);
        chk("b_out_vs_model",  out_b,  mb_out);
        chk("b_rise_vs_model", rise_b, mb_rise);
        chk("b_fall_vs_model", fall_b, mb_fall);
    endtask

    initial begin
        rst     = 1'b1;
        press_a = 4'b1111;
        press_b = 4'b0000;

        // 1. Hold reset with every press bit high, then release.
        $display("phase 1: reset with press=1111");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_rst_out",  out_a,  4'b0000);
            chk("t1_rst_rise", rise_a, 4'b0000);
            chk("t1_rst_fall", fall_a, 4'b0000);
        end
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 5) chk("t1_out_k4", out_a, 4'b0000);
            if (i == 6) begin
                chk("t1_out_k5",  out_a,  4'b1111);
                chk("t1_rise_k5", rise_a, 4'b1111);
                chk("t1_fall_k5", fall_a, 4'b0000);
            end
            if (i == 7) chk("t1_rise_k6", rise_a, 4'b0000);
        end

        // 2. From idle, raise press[0] only.
        $display("phase 2: single channel rise");
        press_a = 4'b0000;
        repeat (8) tick();
        press_a = 4'b0001;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 5) chk("t2_out_k4", out_a, 4'b0000);
            if (i == 6) begin
                chk("t2_out_k5",  out_a,  4'b0001);
                chk("t2_rise_k5", rise_a, 4'b0001);
                chk("t2_fall_k5", fall_a, 4'b0000);
            end
            if (i == 7) chk("t2_rise_k6", rise_a, 4'b0000);
        end

        // 3. A 3-cycle glitch must be rejected; a 4-cycle pulse is accepted.
        $display("phase 3: glitch rejection and minimum pulse");
        press_a = 4'b0000;
        repeat (8) tick();
        press_a = 4'b0010;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 3) press_a = 4'b0000;
            chk("t3_glitch_out",  out_a,  4'b0000);
            chk("t3_glitch_rise", rise_a, 4'b0000);
        end
        press_a = 4'b0010;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 4) press_a = 4'b0000;
            if (i == 5) chk("t3_pulse_out_k4", out_a, 4'b0000);
            if (i == 6) begin
                chk("t3_pulse_out_k5",  out_a,  4'b0010);
                chk("t3_pulse_rise_k5", rise_a, 4'b0010);
            end
            if (i == 9) begin
                chk("t3_pulse_out_k8",  out_a,  4'b0010);
                chk("t3_pulse_fall_k8", fall_a, 4'b0000);
            end
            if (i == 10) begin
                chk("t3_pulse_out_k9",  out_a,  4'b0000);
                chk("t3_pulse_fall_k9", fall_a, 4'b0010);
                chk("t3_pulse_rise_k9", rise_a, 4'b0000);
            end
        end

        // 4. Simultaneous rise and fall on complementary channels.
        $display("phase 4: 1010 -> 0101");
        press_a = 4'b1010;
        repeat (8) tick();
        chk("t4_settled", out_a, 4'b1010);
        press_a = 4'b0101;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 6) begin
                chk("t4_out",  out_a,  4'b0101);
                chk("t4_rise", rise_a, 4'b0101);
                chk("t4_fall", fall_a, 4'b1010);
            end
            if (i == 7) begin
                chk("t4_rise_next", rise_a, 4'b0000);
                chk("t4_fall_next", fall_a, 4'b0000);
            end
        end

        // 5. Assert reset between edges while a count is in progress.
        $display("phase 5: async reset mid-count");
        press_a = 4'b0001;
        repeat (8) tick();
        chk("t5_settled", out_a, 4'b0001);
        press_a = 4'b0101;
        tick();
        tick();
        @(posedge clk);
        #20 rst = 1'b1;
        #5;
        chk("t5_async_out",  out_a,  4'b0000);
        chk("t5_async_rise", rise_a, 4'b0000);
        chk("t5_async_fall", fall_a, 4'b0000);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            if (i == 5) chk("t5_out_k4", out_a, 4'b0000);
            if (i == 6) begin
                chk("t5_out_k5",  out_a,  4'b0101);
                chk("t5_rise_k5", rise_a, 4'b0101);
            end
            if (i == 7) chk("t5_rise_k6", rise_a, 4'b0000);
        end

        // 6. Variant with STAGES=3 and DB_CYCLES=1.
        $display("phase 6: STAGES=3 DB_CYCLES=1 variant");
        press_b = 4'b1000;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 3) chk("t6_out_k2", out_b, 4'b0000);
            if (i == 4) begin
                chk("t6_out_k3",  out_b,  4'b1000);
                chk("t6_rise_k3", rise_b, 4'b1000);
            end
            if (i == 5) chk("t6_rise_k4", rise_b, 4'b0000);
        end
        press_b = 4'b0000;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 4) begin
                chk("t6_fall_out",  out_b,  4'b0000);
                chk("t6_fall_k3",   fall_b, 4'b1000);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
